// File: rtl/sr_latch_pkg.sv
// Shared constants and helpers for the sr_latch_bank flag-storage block.
// S=R=1 policy encodings plus a popcount used to total per-edge q transitions.
package sr_latch_pkg;

  localparam int MODE_RST_DOM = 0;
  localparam int MODE_SET_DOM = 1;
  localparam int MODE_HOLD    = 2;
  localparam int MODE_TOGGLE  = 3;

  // Covers the full 1..32 channel range; callers narrow the result to their width.
  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + 6'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/sr_cell.sv
// One set/reset storage channel: next-state policy, edge pulses and sticky err flag.
// With SR_LATCH_BANK_FILTER_EN defined, s/r must be stable on two enabled edges to act.
module sr_cell
  import sr_latch_pkg::*;
#(
  parameter int MODE = MODE_RST_DOM
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic s,
  input  logic r,
  input  logic clr_err,
  output logic q,
  output logic q_rise,
  output logic q_fall,
  output logic err,
  output logic chg
);

  logic q_q, q_d;
  logic q_rise_q, q_rise_d;
  logic q_fall_q, q_fall_d;
  logic err_q, err_d;
  logic s_eff, r_eff;

`ifdef SR_LATCH_BANK_FILTER_EN
  logic s_p_q, s_p_d;
  logic r_p_q, r_p_d;
  logic stable;

  // The previous sample only advances on enabled edges, so en=0 freezes the filter.
  always_comb begin
    s_p_d  = s_p_q;
    r_p_d  = r_p_q;
    stable = (s == s_p_q) && (r == r_p_q);
    s_eff  = s & stable;
    r_eff  = r & stable;
    if (en) begin
      s_p_d = s;
      r_p_d = r;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_p_q <= 1'b0;
      r_p_q <= 1'b0;
    end else begin
      s_p_q <= s_p_d;
      r_p_q <= r_p_d;
    end
  end
`else
  always_comb begin
    s_eff = s;
    r_eff = r;
  end
`endif

  always_comb begin
    q_d = q_q;
    if (en) begin
      case ({s_eff, r_eff})
        2'b10:   q_d = 1'b1;
        2'b01:   q_d = 1'b0;
        2'b11: begin
          case (MODE)
            MODE_RST_DOM: q_d = 1'b0;
            MODE_SET_DOM: q_d = 1'b1;
            MODE_TOGGLE:  q_d = ~q_q;
            default:      q_d = q_q;
          endcase
        end
        default: q_d = q_q;
      endcase
    end
    q_rise_d = q_d & ~q_q;
    q_fall_d = ~q_d & q_q;
    // A new invalid request beats a simultaneous clear.
    err_d    = (en & s_eff & r_eff) | (err_q & ~clr_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q      <= 1'b0;
      q_rise_q <= 1'b0;
      q_fall_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      q_q      <= q_d;
      q_rise_q <= q_rise_d;
      q_fall_q <= q_fall_d;
      err_q    <= err_d;
    end
  end

  assign q      = q_q;
  assign q_rise = q_rise_q;
  assign q_fall = q_fall_q;
  assign err    = err_q;
  assign chg    = q_rise_d | q_fall_d;

endmodule

// File: rtl/sr_latch_bank.sv
// CH clocked set/reset flag channels with a shared enable and a saturating transition counter.
// Optional input stability filter in each channel: SR_LATCH_BANK_FILTER_EN.
module sr_latch_bank
  import sr_latch_pkg::*;
#(
  parameter int CH    = 4,
  parameter int MODE  = MODE_RST_DOM,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CH-1:0]    s,
  input  logic [CH-1:0]    r,
  input  logic             clr_err,
  input  logic             clr_cnt,
  output logic [CH-1:0]    q,
  output logic [CH-1:0]    q_rise,
  output logic [CH-1:0]    q_fall,
  output logic [CH-1:0]    err,
  output logic [CNT_W-1:0] chg_cnt
);

  localparam int PC_W = $clog2(CH + 1);

  logic [CH-1:0]    chg;
  logic [PC_W-1:0]  chg_pc;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] chg_cnt_q, chg_cnt_d;

  for (genvar i = 0; i < CH; i++) begin : g_cell
    sr_cell #(.MODE(MODE)) u_cell (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .s       (s[i]),
      .r       (r[i]),
      .clr_err (clr_err),
      .q       (q[i]),
      .q_rise  (q_rise[i]),
      .q_fall  (q_fall[i]),
      .err     (err[i]),
      .chg     (chg[i])
    );
  end

  // One extra bit of headroom makes the overflow test a single MSB check.
  always_comb begin
    chg_pc    = PC_W'(popcount(32'(chg)));
    sum       = (CNT_W + 1)'(chg_cnt_q) + (CNT_W + 1)'(chg_pc);
    chg_cnt_d = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    if (clr_cnt) begin
      chg_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chg_cnt_q <= '0;
    end else begin
      chg_cnt_q <= chg_cnt_d;
    end
  end

  assign chg_cnt = chg_cnt_q;

endmodule
